banco_registros_param: RTL and testbench

- Parametrised, clocked register file; successor to the team's combinational 32x32 register bank.
- Sits between decode (read and reserve) and writeback (write) of the CPU datapath.
- Adds a synchronous reset, an optional hardwired zero register, and write-to-read bypass.
- Adds an optional registered read stage and a per-register pending scoreboard so hazard logic can stall on operands not yet written.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 47 ++++
 rtl/banco_registros_param.sv | 103 ++++++++++
 tb/tb_banco_registros_param.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file.
package regfile_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;

  typedef logic [DefDataW-1:0] reg_data_t;
  typedef logic [DefAddrW-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: a reserve marks a register as awaiting its producer,
// a write clears it, and BUSY flags reads of registers still in flight.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_eff,
  input  logic [ADDR_W-1:0] aw,
  input  logic              res_en,
  input  logic [ADDR_W-1:0] ar_res,
  input  logic [ADDR_W-1:0] ar_1,
  input  logic [ADDR_W-1:0] ar_2,
  output logic              busy_1,
  output logic              busy_2
);

  localparam int unsigned Depth  = 2 ** ADDR_W;
  localparam bit          ZeroEn = (ZERO_REG != 0);

  logic [Depth-1:0] pend_q, pend_d;
  logic             res_eff;

  assign res_eff = res_en & ~(ZeroEn && (ar_res == ADDR_W'(ZERO_ADDR)));

  // Set is applied after clear so a fresh reservation wins over a same-cycle write.
  always_comb begin
    pend_d = pend_q;
    if (we_eff) pend_d[aw] = 1'b0;
    if (res_eff) pend_d[ar_res] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  // A write in flight to the same register resolves the hazard through the bypass.
  always_comb begin
    busy_1 = pend_q[ar_1] & ~(we_eff && (aw == ar_1));
    busy_2 = pend_q[ar_2] & ~(we_eff && (aw == ar_2));
  end

endmodule

// File: rtl/banco_registros_param.sv
// Clocked two-read / one-write register file with write bypass, optional zero
// register, optional registered read stage and a pending-operand scoreboard.
module banco_registros_param
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned READ_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] AR_1,
  input  logic [ADDR_W-1:0] AR_2,
  input  logic              RE,
  input  logic [ADDR_W-1:0] AW,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              WRITEREG,
  input  logic              RES_EN,
  input  logic [ADDR_W-1:0] AR_RES,
  output logic [DATA_W-1:0] DR_1,
  output logic [DATA_W-1:0] DR_2,
  output logic              BUSY_1,
  output logic              BUSY_2,
  output logic              VALID
);

  localparam int unsigned Depth  = 2 ** ADDR_W;
  localparam bit          ZeroEn = (ZERO_REG != 0);

  logic [DATA_W-1:0] banco_q [Depth];
  logic              we_eff;
  logic [DATA_W-1:0] rd_1, rd_2;

  assign we_eff = WRITEREG & ~(ZeroEn && (AW == ADDR_W'(ZERO_ADDR)));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) banco_q[i] <= '0;
    end else if (we_eff) begin
      banco_q[AW] <= DATA_IN;
    end
  end

  always_comb begin
    if (ZeroEn && (AR_1 == ADDR_W'(ZERO_ADDR))) rd_1 = '0;
    else if (we_eff && (AW == AR_1))            rd_1 = DATA_IN;
    else                                        rd_1 = banco_q[AR_1];

    if (ZeroEn && (AR_2 == ADDR_W'(ZERO_ADDR))) rd_2 = '0;
    else if (we_eff && (AW == AR_2))            rd_2 = DATA_IN;
    else                                        rd_2 = banco_q[AR_2];
  end

  generate
    if (READ_LAT == 0) begin : g_comb_read
      logic unused_re;
      assign unused_re = RE;
      assign DR_1  = rd_1;
      assign DR_2  = rd_2;
      assign VALID = 1'b1;
    end else begin : g_reg_read
      logic [DATA_W-1:0] dr_1_q, dr_2_q;
      logic              valid_q;

      // Outputs hold while RE is low; VALID marks only the cycle after a read.
      always_ff @(posedge clk) begin
        if (rst) begin
          dr_1_q  <= '0;
          dr_2_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= RE;
          if (RE) begin
            dr_1_q <= rd_1;
            dr_2_q <= rd_2;
          end
        end
      end

      assign DR_1  = dr_1_q;
      assign DR_2  = dr_2_q;
      assign VALID = valid_q;
    end
  endgenerate

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk   (clk),
    .rst   (rst),
    .we_eff(we_eff),
    .aw    (AW),
    .res_en(RES_EN),
    .ar_res(AR_RES),
    .ar_1  (AR_1),
    .ar_2  (AR_2),
    .busy_1(BUSY_1),
    .busy_2(BUSY_2)
  );

endmodule

// File: tb/tb_banco_registros_param.sv
// Scoreboard bench: one combinational-read and one registered-read instance share stimulus.
module tb_banco_registros_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ar_1, ar_2, aw, ar_res;
  logic        re, writereg, res_en;
  logic [31:0] data_in;

  logic [31:0] dr_1_l0, dr_2_l0, dr_1_l1, dr_2_l1;
  logic        busy_1_l0, busy_2_l0, busy_1_l1, busy_2_l1, valid_l0, valid_l1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    int          inst;
    string       name;
    logic [31:0] dr1, dr2;
    logic        b1, b2, v;
    bit          ck_dr, ck_busy, ck_v;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  banco_registros_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .READ_LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .AR_1(ar_1), .AR_2(ar_2), .RE(re), .AW(aw), .DATA_IN(data_in),
    .WRITEREG(writereg), .RES_EN(res_en), .AR_RES(ar_res), .DR_1(dr_1_l0), .DR_2(dr_2_l0),
    .BUSY_1(busy_1_l0), .BUSY_2(busy_2_l0), .VALID(valid_l0)
  );

  banco_registros_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .READ_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .AR_1(ar_1), .AR_2(ar_2), .RE(re), .AW(aw), .DATA_IN(data_in),
    .WRITEREG(writereg), .RES_EN(res_en), .AR_RES(ar_res), .DR_1(dr_1_l1), .DR_2(dr_2_l1),
    .BUSY_1(busy_1_l1), .BUSY_2(busy_2_l1), .VALID(valid_l1)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every queued expectation due this cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      exp_t e;
      e = sb[i];
      if (e.cyc == cyc) begin
        if (e.inst == 0) begin
          if (e.ck_dr) begin
            cmp({e.name, ".lat0.dr1"}, dr_1_l0, e.dr1);
            cmp({e.name, ".lat0.dr2"}, dr_2_l0, e.dr2);
          end
          if (e.ck_busy) begin
            cmp({e.name, ".lat0.busy1"}, 32'(busy_1_l0), 32'(e.b1));
            cmp({e.name, ".lat0.busy2"}, 32'(busy_2_l0), 32'(e.b2));
          end
          if (e.ck_v) cmp({e.name, ".lat0.valid"}, 32'(valid_l0), 32'(e.v));
        end else begin
          if (e.ck_dr) begin
            cmp({e.name, ".lat1.dr1"}, dr_1_l1, e.dr1);
            cmp({e.name, ".lat1.dr2"}, dr_2_l1, e.dr2);
          end
          if (e.ck_busy) begin
            cmp({e.name, ".lat1.busy1"}, 32'(busy_1_l1), 32'(e.b1));
            cmp({e.name, ".lat1.busy2"}, 32'(busy_2_l1), 32'(e.b2));
          end
          if (e.ck_v) cmp({e.name, ".lat1.valid"}, 32'(valid_l1), 32'(e.v));
        end
        sb.delete(i);
      end else if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d never sampled, now cycle %0d",
                 e.name, e.cyc, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic push(input int c, input int inst, input string name,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic b1, input logic b2, input logic v,
                      input bit ck_dr, input bit ck_busy, input bit ck_v);
    exp_t e;
    e.cyc = c; e.inst = inst; e.name = name;
    e.dr1 = d1; e.dr2 = d2; e.b1 = b1; e.b2 = b2; e.v = v;
    e.ck_dr = ck_dr; e.ck_busy = ck_busy; e.ck_v = ck_v;
    sb.push_back(e);
  endtask

  // Lat0 sees the current-cycle read; lat1 shows its data after the closing edge.
  task automatic expect_cyc(input string name,
                            input logic [31:0] d1_0, input logic [31:0] d2_0,
                            input logic b1, input logic b2,
                            input logic [31:0] d1_1, input logic [31:0] d2_1, input logic v1);
    push(cyc, 0, name, d1_0, d2_0, b1, b2, 1'b1, 1'b1, 1'b1, 1'b1);
    push(cyc, 1, name, '0, '0, b1, b2, 1'b0, 1'b0, 1'b1, 1'b0);
    push(cyc + 1, 1, name, d1_1, d2_1, 1'b0, 1'b0, v1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic drive(input logic r, input logic we, input logic [4:0] a_w,
                       input logic [31:0] din, input logic res, input logic [4:0] a_res,
                       input logic [4:0] a1, input logic [4:0] a2, input logic rd_en);
    @(posedge clk);
    #1;
    rst = r; writereg = we; aw = a_w; data_in = din;
    res_en = res; ar_res = a_res; ar_1 = a1; ar_2 = a2; re = rd_en;
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] A5 = 32'hA5A5A5A5;

  initial begin
    rst = 1'b1; writereg = 1'b0; aw = '0; data_in = '0;
    res_en = 1'b0; ar_res = '0; ar_1 = '0; ar_2 = '0; re = 1'b0;

    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      push(cyc + 1, 1, "reset", '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    end

    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a), 0);
      expect_cyc("post_reset_read", 0, 0, 0, 0, 0, 0, 0);
    end

    drive(0, 1, 5, DB, 0, 0, 0, 0, 0);           expect_cyc("write5", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 5, 0, 1);            expect_cyc("read5", DB, 0, 0, 0, DB, 0, 1);
    drive(0, 1, 0, 32'h1234, 0, 0, 0, 5, 1);     expect_cyc("write0", 0, DB, 0, 0, 0, DB, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);            expect_cyc("read0", 0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 7, A5, 0, 0, 7, 7, 1);           expect_cyc("bypass7", A5, A5, 0, 0, A5, A5, 1);
    drive(0, 0, 0, 0, 0, 0, 7, 7, 0);            expect_cyc("re_low", A5, A5, 0, 0, A5, A5, 0);
    drive(0, 0, 0, 0, 0, 0, 5, 7, 1);            expect_cyc("re_high", DB, A5, 0, 0, DB, A5, 1);

    drive(0, 0, 0, 0, 1, 9, 9, 9, 0);            expect_cyc("res9", 0, 0, 0, 0, DB, A5, 0);
    drive(0, 0, 0, 0, 0, 0, 9, 9, 1);            expect_cyc("busy9", 0, 0, 1, 1, 0, 0, 1);
    drive(0, 1, 9, 32'h99, 0, 0, 9, 9, 1);       expect_cyc("write9_bypass", 32'h99, 32'h99,
                                                            0, 0, 32'h99, 32'h99, 1);
    drive(0, 0, 0, 0, 0, 0, 9, 9, 1);            expect_cyc("after_write9", 32'h99, 32'h99,
                                                            0, 0, 32'h99, 32'h99, 1);
    drive(0, 1, 9, 32'h1111, 1, 9, 9, 9, 1);     expect_cyc("res_and_write9", 32'h1111, 32'h1111,
                                                            0, 0, 32'h1111, 32'h1111, 1);
    drive(0, 0, 0, 0, 0, 0, 9, 9, 1);            expect_cyc("set_wins", 32'h1111, 32'h1111,
                                                            1, 1, 32'h1111, 32'h1111, 1);
    drive(0, 0, 0, 0, 1, 9, 9, 3, 1);            expect_cyc("rereserve9", 32'h1111, 0,
                                                            1, 0, 32'h1111, 0, 1);
    drive(0, 0, 0, 0, 1, 3, 9, 3, 1);            expect_cyc("res3", 32'h1111, 0, 1, 0,
                                                            32'h1111, 0, 1);
    drive(0, 0, 0, 0, 1, 4, 3, 4, 1);            expect_cyc("res4", 0, 0, 1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0, 4, 0, 1);            expect_cyc("res0", 0, 0, 1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 9, 1);            expect_cyc("zero_never_busy", 0, 32'h1111,
                                                            0, 1, 0, 32'h1111, 1);

    drive(1, 1, 3, 32'hFF, 1, 5, 3, 4, 1);       expect_cyc("reset_wins", 32'hFF, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 3, 4, 0);            expect_cyc("after_reset34", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 9, 5, 1);            expect_cyc("after_reset95", 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors += sb.size();
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
